// File: rtl/la_iopoc_pkg.sv
// ==========================================================================
// la_iopoc_pkg : shared types and ring-bit helpers for the ioring power-on sequencer
// Rev 1.0
// ==========================================================================
`default_nettype none

package la_iopoc_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_SETTLE  = 3'd1,
    S_IE_ON   = 3'd2,
    S_ISO_OFF = 3'd3,
    S_ACTIVE  = 3'd4,
    S_DRAIN   = 3'd5,
    S_SLEEP   = 3'd6
  } state_e;

  localparam int ISO     = 0;
  localparam int IE      = 1;
  localparam int OE      = 2;
  localparam int POC     = 3;
  localparam int CFG_LSB = 4;

  localparam logic [3:0] RING_SAFE = 4'b1001;

  // Control nibble presented on ioring[3:0] while resident in state s.
  function automatic logic [3:0] ring_bits(state_e s);
    logic [3:0] r;
    r      = '0;
    r[POC] = (s inside {S_OFF, S_SETTLE});
    r[ISO] = (s inside {S_OFF, S_SETTLE, S_IE_ON, S_SLEEP});
    r[IE]  = (s inside {S_IE_ON, S_ISO_OFF, S_ACTIVE, S_DRAIN, S_SLEEP});
    r[OE]  = (s == S_ACTIVE);
    return r;
  endfunction

  function automatic logic cfg_open(state_e s);
    return (s inside {S_OFF, S_SETTLE, S_SLEEP});
  endfunction

endpackage

`default_nettype wire

// File: rtl/la_iopocseq_sync.sv
// ==========================================================================
// la_iopocseq_sync : reset-clearing multi-flop synchronizer for io power-good
// Rev 1.0
// ==========================================================================
`default_nettype none

module la_iopocseq_sync #(
  parameter string PROP   = "DEFAULT",
  parameter int    PGSYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [PGSYNC-1:0] sync_q;

  // Non-default properties map onto a hardened synchronizer cell in the vendor flow.
  generate
    if (PROP == "DEFAULT") begin : g_generic
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[PGSYNC-2:0], async_i};
      end
    end else begin : g_cell
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[PGSYNC-2:0], async_i};
      end
    end
  endgenerate

  assign sync_o = sync_q[PGSYNC-1];

endmodule

`default_nettype wire

// File: rtl/la_iopocseq.sv
// ==========================================================================
// la_iopocseq : core-side power-on sequencer driving the generic ioring bus
// Rev 1.0
// ==========================================================================
`default_nettype none

module la_iopocseq
  import la_iopoc_pkg::*;
#(
  parameter string             PROP   = "DEFAULT",
  parameter int                RINGW  = 8,
  parameter int                PGSYNC = 2,
  parameter int                TISO   = 16,
  parameter int                TSTEP  = 4,
  parameter logic [RINGW-5:0]  CFGRST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pg,
  input  logic             sleep_req,
  output logic             sleep_ack,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [RINGW-5:0] cfg_data,
  output logic [2:0]       status,
  output logic [RINGW-1:0] ioring
);

  localparam int CNTW = $clog2((TISO > TSTEP) ? TISO : TSTEP) + 1;
  localparam logic [CNTW-1:0] c_iso_last  = CNTW'(TISO - 1);
  localparam logic [CNTW-1:0] c_step_last = CNTW'(TSTEP - 1);

  logic             pg_sync;
  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [3:0]       ring_q;
  logic [RINGW-5:0] cfg_q, cfg_d;
  logic             sleep_ack_q;
  logic             cfg_ready_q;

  la_iopocseq_sync #(
    .PROP   (PROP),
    .PGSYNC (PGSYNC)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (pg),
    .sync_o  (pg_sync)
  );

  // Loss of power-good overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (state_q != S_OFF && !pg_sync) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF:     if (pg_sync)              state_d = S_SETTLE;
        S_SETTLE:  if (cnt_q == c_iso_last)  state_d = S_IE_ON;
        S_IE_ON:   if (cnt_q == c_step_last) state_d = S_ISO_OFF;
        S_ISO_OFF: if (cnt_q == c_step_last) state_d = S_ACTIVE;
        S_ACTIVE:  if (sleep_req)            state_d = S_DRAIN;
        S_DRAIN:   if (cnt_q == c_step_last) state_d = S_SLEEP;
        S_SLEEP:   if (!sleep_req)           state_d = S_ISO_OFF;
        default:                             state_d = S_OFF;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || state_q == S_OFF) cnt_d = '0;
    else if (cnt_q != '1)                       cnt_d = cnt_q + 1'b1;
  end

  assign cfg_d = (cfg_valid && cfg_ready_q) ? cfg_data : cfg_q;

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      ring_q      <= RING_SAFE;
      cfg_q       <= CFGRST;
      sleep_ack_q <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ring_q      <= ring_bits(state_d);
      cfg_q       <= cfg_d;
      sleep_ack_q <= (state_d == S_SLEEP);
      cfg_ready_q <= cfg_open(state_d);
    end
  end

  assign status                 = state_q;
  assign sleep_ack              = sleep_ack_q;
  assign cfg_ready              = cfg_ready_q;
  assign ioring[CFG_LSB-1:0]    = ring_q;
  assign ioring[RINGW-1:CFG_LSB] = cfg_q;

endmodule

`default_nettype wire

// File: tb/tb_la_iopocseq.sv
// ==========================================================================
// tb_la_iopocseq : directed + randomized bench for la_iopocseq with a cycle reference model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_la_iopocseq;

  localparam int RINGW  = 8;
  localparam int PGSYNC = 2;
  localparam int TISO   = 16;
  localparam int TSTEP  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pg = 1'b0;
  logic             sleep_req = 1'b0;
  logic             sleep_ack;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [RINGW-5:0] cfg_data = '0;
  logic [2:0]       status;
  logic [RINGW-1:0] ioring;

  int ncmp  = 0;
  int nfail = 0;

  la_iopocseq #(
    .PROP   ("DEFAULT"),
    .RINGW  (RINGW),
    .PGSYNC (PGSYNC),
    .TISO   (TISO),
    .TSTEP  (TSTEP),
    .CFGRST ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pg        (pg),
    .sleep_req (sleep_req),
    .sleep_ack (sleep_ack),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .status    (status),
    .ioring    (ioring)
  );

  always #5 clk = ~clk;

  // Reference model: state number per the published encoding, cycles spent in state.
  int         m_state = 0;
  int         m_dwell = 0;
  logic       m_pipe [PGSYNC];
  logic [3:0] m_cfg = '0;

  function automatic logic [3:0] m_ring(int s);
    case (s)
      0, 1:    return 4'h9;
      2, 6:    return 4'h3;
      3, 5:    return 4'h2;
      4:       return 4'h6;
      default: return 4'h9;
    endcase
  endfunction

  function automatic logic m_ready(int s);
    return (s == 0 || s == 1 || s == 6);
  endfunction

  task automatic model_step(input logic r, input logic p, input logic sr,
                            input logic cv, input logic [3:0] cd);
    logic pgs;
    int   ns;
    if (r) begin
      m_state = 0;
      m_dwell = 0;
      m_cfg   = '0;
      for (int k = 0; k < PGSYNC; k++) m_pipe[k] = 1'b0;
      return;
    end
    pgs = m_pipe[PGSYNC-1];
    for (int k = PGSYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = p;
    if (cv && m_ready(m_state)) m_cfg = cd;
    ns = m_state;
    if (m_state != 0 && !pgs) ns = 0;
    else begin
      case (m_state)
        0: if (pgs) ns = 1;
        1: if (m_dwell == TISO - 1) ns = 2;
        2: if (m_dwell == TSTEP - 1) ns = 3;
        3: if (m_dwell == TSTEP - 1) ns = 4;
        4: if (sr) ns = 5;
        5: if (m_dwell == TSTEP - 1) ns = 6;
        6: if (!sr) ns = 3;
        default: ns = 0;
      endcase
    end
    m_dwell = (ns != m_state) ? 0 : m_dwell + 1;
    m_state = ns;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic r, p, sr, cv;
    logic [3:0] cd;
    r = reset; p = pg; sr = sleep_req; cv = cfg_valid; cd = cfg_data;
    @(posedge clk);
    model_step(r, p, sr, cv, cd);
    #1;
    chk("ioring",    32'(ioring),    32'({m_cfg, m_ring(m_state)}));
    chk("status",    32'(status),    32'(m_state));
    chk("sleep_ack", 32'(sleep_ack), 32'(m_state == 6));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(m_state)));
  endtask

  initial begin
    int t_ie, t_iso, t_act, pg_hold, sr_hold;

    for (int k = 0; k < PGSYNC; k++) m_pipe[k] = 1'b0;

    // Reset held with pg low.
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_ring", 32'(ioring), 32'h09);
      chk("rst_ready", 32'(cfg_ready), 32'h1);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Short power-good pulse aborts during SETTLE.
    pg = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_ring", 32'(ioring), 32'h09);
    end
    pg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_ring", 32'(ioring), 32'h09);
    end
    chk("abort_status", 32'(status), 32'h0);

    // Clean rise: measure step latencies.
    t_ie = 0; t_iso = 0; t_act = 0;
    pg = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (t_ie  == 0 && ioring == 8'h03) t_ie  = i;
      if (t_iso == 0 && ioring == 8'h02) t_iso = i;
      if (t_act == 0 && ioring == 8'h06) t_act = i;
    end
    chk("lat_ie_on",   32'(t_ie),  32'd19);
    chk("lat_iso_off", 32'(t_iso), 32'd23);
    chk("lat_active",  32'(t_act), 32'd27);
    chk("active_status", 32'(status), 32'd4);

    // Config write blocked in ACTIVE, then sleep entry.
    cfg_valid = 1'b1; cfg_data = 4'hA;
    tick();
    chk("cfg_blocked_ready", 32'(cfg_ready), 32'h0);
    chk("cfg_blocked_bits",  32'(ioring[7:4]), 32'h0);
    sleep_req = 1'b1;
    tick();
    chk("drain_ring", 32'(ioring), 32'h02);
    for (int i = 0; i < 3; i++) tick();
    chk("drain_hold", 32'(ioring), 32'h02);
    tick();
    chk("sleep_ring", 32'(ioring), 32'h03);
    chk("sleep_ack",  32'(sleep_ack), 32'h1);
    tick();
    chk("cfg_accept", 32'(ioring), 32'hA3);
    cfg_valid = 1'b0;
    sleep_req = 1'b0;
    tick();
    chk("wake_ring", 32'(ioring), 32'hA2);
    chk("wake_ack",  32'(sleep_ack), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("wake_active", 32'(ioring), 32'hA6);

    // Power loss in ACTIVE.
    pg = 1'b0;
    tick(); tick();
    chk("pgloss_hold", 32'(ioring), 32'hA6);
    tick();
    chk("pgloss_ring",   32'(ioring), 32'hA9);
    chk("pgloss_status", 32'(status), 32'h0);
    chk("pgloss_ack",    32'(sleep_ack), 32'h0);

    reset = 1'b1;
    tick();
    chk("reset_cfg", 32'(ioring), 32'h09);
    reset = 1'b0;

    // Randomized traffic against the model.
    pg_hold = 0; sr_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pg_hold == 0) begin
        pg = ($urandom_range(0, 99) < 85);
        pg_hold = $urandom_range(1, 60);
      end else pg_hold--;
      if (sr_hold == 0) begin
        sleep_req = $urandom_range(0, 1);
        sr_hold = $urandom_range(1, 25);
      end else sr_hold--;
      cfg_valid = ($urandom_range(0, 9) < 3);
      cfg_data  = 4'($urandom);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/la_iopocseq.md
Name: la_iopocseq

Overview:
Core-side power-on sequencer that drives the generic ioring control bus consumed by the power-on control cell and the pad cells.
- Synchronizes the asynchronous io-domain power-good indication.
- Steps the ring through a safe power-up order: power-on-control, input enable, isolation release, output enable.
- Provides a sleep/wake handshake to core logic.
- Loads static pad configuration bits onto the upper ring bits via a valid/ready port.

Parameters:
PROP, "DEFAULT", cell property string, passed through for implementation selection
RINGW, 8, width of ioring; must be >= 5
PGSYNC, 2, power-good synchronizer depth in flops (>= 2)
TISO, 16, cycles of continuous synchronized power-good required before release (>= 1)
TSTEP, 4, cycles between successive sequencing steps (>= 1)
CFGRST, 0, reset value of the configuration bits ioring[RINGW-1:4]

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
pg  input  1  power-good from io supply domain, asynchronous to clk
sleep_req  input  1  core request to park the pads (level)
sleep_ack  output  1  pads parked; high only in SLEEP
cfg_valid  input  1  configuration write valid
cfg_ready  output  1  configuration write accepted when high with cfg_valid
cfg_data  input  RINGW-4  configuration bits for ioring[RINGW-1:4]
status  output  3  current state encoding
ioring  output  RINGW  bit0 iso, bit1 ie, bit2 oe, bit3 poc (active high), [RINGW-1:4] config

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (port reset).
- Reset values:
  - state OFF; ioring[3:0]=4'b1001; ioring[RINGW-1:4]=CFGRST
  - sleep_ack=0; cfg_ready=1; status=0
  - synchronizer flops and counter cleared
- Outputs: all outputs are registered. pg_sync is pg after PGSYNC flops.
- States, with encoding and ioring[3:0] (poc, oe, ie, iso):
  - OFF (0), 1001: pg_sync=1 -> SETTLE, counter cleared.
  - SETTLE (1), 1001: counter increments while pg_sync=1. At counter==TISO-1 -> IE_ON. pg_sync=0 -> OFF.
  - IE_ON (2), 0011: after TSTEP cycles -> ISO_OFF.
  - ISO_OFF (3), 0010: after TSTEP cycles -> ACTIVE.
  - ACTIVE (4), 0110: sleep_req=1 -> DRAIN.
  - DRAIN (5), 0010: after TSTEP cycles -> SLEEP.
  - SLEEP (6), 0011, sleep_ack=1: sleep_req=0 -> ISO_OFF (wake reuses the release step).
- Step timing: TSTEP counting starts on state entry, so a state is held exactly TSTEP cycles.
- Power loss: pg_sync=0 in any non-OFF state forces OFF on the next edge. This has priority over all other transitions, including sleep_req and counter expiry. sleep_ack drops with it.
- Sleep handshake:
  - sleep_req deasserted during DRAIN is ignored until SLEEP is reached.
  - Wake from SLEEP clears sleep_ack on the same edge that enters ISO_OFF.
- Config port:
  - cfg_ready=1 in OFF, SETTLE and SLEEP, else 0.
  - On cfg_valid & cfg_ready, ioring[RINGW-1:4] takes cfg_data on the next edge.
  - cfg_data is not required to hold while cfg_ready=0.
  - Reset mid-write discards the write.
- Counter:
  - Width clog2(max(TISO,TSTEP))+1; saturates, never wraps.
  - Cleared on every state change.
- No combinational path from any input to any output.

Decomposition:
- Package la_iopoc_pkg holds:
  - state enum with the encodings above
  - ring bit index constants (ISO=0, IE=1, OE=2, POC=3, CFG_LSB=4)
  - safe-off ring pattern 4'b1001
- One sub-module, la_iopocseq_sync: PGSYNC-deep reset-clearing synchronizer for pg.
- FSM, counter and config register stay in la_iopocseq.

Test Plan:
All scenarios use defaults (RINGW=8, PGSYNC=2, TISO=16, TSTEP=4, CFGRST=0).
1. Reset with pg=0 held 10 cycles -> ioring=8'h09, status=0, cfg_ready=1, sleep_ack=0 throughout.
2. pg rises at cycle 0, held high:
   - ioring=8'h03 first at cycle 19 (2 sync + 1 + 16)
   - ioring=8'h02 at 23
   - ioring=8'h06 at 27, status=4
3. pg high 10 cycles then low during SETTLE -> returns to OFF; ioring never leaves 8'h09. A second clean pg rise reaches ACTIVE with the same 27-cycle latency.
4. In ACTIVE, assert sleep_req:
   - ioring=8'h02 next cycle
   - 4 cycles later ioring=8'h03 and sleep_ack=1
   - deassert sleep_req: sleep_ack=0 and ioring=8'h02 next cycle, ioring=8'h06 4 cycles later
5. pg drops in ACTIVE -> ioring=8'h09 and status=0 exactly 3 cycles later, sleep_ack=0, config bits retained.
6. Config write:
   - cfg_valid=1, cfg_data=4'hA in ACTIVE -> cfg_ready=0, ioring[7:4] unchanged
   - same write held into SLEEP -> accepted; ioring=8'hA3 next cycle
   - reset then restores ioring=8'h09
